// File: rtl/param_negedge_univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control/data inputs and
// register/serial/counter outputs.
interface param_negedge_univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             en;
  logic [1:0]       mode;
  logic             rot;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] cnt;
  logic             done;

  modport master (
    output en, mode, rot, sin_r, sin_l, d,
    input  q, sout_r, sout_l, cnt, done
  );

  modport slave (
    input  en, mode, rot, sin_r, sin_l, d,
    output q, sout_r, sout_l, cnt, done
  );
endinterface

// File: rtl/param_negedge_univ_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load,
// optional rotate) with a shift counter that pulses done every WIDTH shifts.
// The active clock edge is chosen at build time; only one edge is ever used.
module param_negedge_univ_shift_reg #(
  parameter int               WIDTH    = 8,
  parameter bit               NEG_EDGE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               CNT_W    = 5
) (
  input logic                          clk,
  input logic                          rst_n,
  param_negedge_univ_shift_reg_if.slave bus
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_in;
  logic             shifting;

  // Next-state: data path by mode, then the shared shift counter.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_in = 1'b0;
    shifting = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_RIGHT: begin
          shift_in = bus.rot ? q_q[0] : bus.sin_r;
          q_d      = {shift_in, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LEFT: begin
          shift_in = bus.rot ? q_q[WIDTH-1] : bus.sin_l;
          q_d      = {q_q[WIDTH-2:0], shift_in};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    // Both directions advance the same count; done marks the WIDTH-th shift.
    if (shifting) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register on the build-time-selected edge, async active-low reset.
  generate
    if (NEG_EDGE) begin : g_neg_edge
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_q    <= RST_VAL;
          cnt_q  <= '0;
          done_q <= 1'b0;
        end else begin
          q_q    <= q_d;
          cnt_q  <= cnt_d;
          done_q <= done_d;
        end
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_q    <= RST_VAL;
          cnt_q  <= '0;
          done_q <= 1'b0;
        end else begin
          q_q    <= q_d;
          cnt_q  <= cnt_d;
          done_q <= done_d;
        end
      end
    end
  endgenerate

  // Serial outputs are taps of q, no extra register stage.
  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.cnt    = cnt_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_param_negedge_univ_shift_reg.sv
// Bench for the universal shift register: a falling-edge build (RST_VAL A5)
// and a rising-edge build (RST_VAL 5A) share clk and rst_n.
module tb_param_negedge_univ_shift_reg;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  param_negedge_univ_shift_reg_if #(.WIDTH(W), .CNT_W(5)) bus_n ();
  param_negedge_univ_shift_reg_if #(.WIDTH(W), .CNT_W(5)) bus_p ();

  param_negedge_univ_shift_reg #(
    .WIDTH(W), .NEG_EDGE(1'b1), .RST_VAL(8'hA5), .CNT_W(5)
  ) u_neg (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  param_negedge_univ_shift_reg #(
    .WIDTH(W), .NEG_EDGE(1'b0), .RST_VAL(8'h5A), .CNT_W(5)
  ) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sr;
    logic       sl;
    logic [7:0] d;
    logic [7:0] eq;
    logic [4:0] ecnt;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: total shifts since load/reset, modulo W.
  logic [7:0] m_q;
  int         m_shifts;
  logic       m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [1:0] mode, input logic rot,
                     input logic sr, input logic sl, input logic [7:0] d,
                     input logic [7:0] eq, input logic [4:0] ecnt, input logic edone);
    vec_t v;
    v.en = en; v.mode = mode; v.rot = rot; v.sr = sr; v.sl = sl; v.d = d;
    v.eq = eq; v.ecnt = ecnt; v.edone = edone;
    tbl.push_back(v);
  endtask

  task automatic drive_n(input logic en, input logic [1:0] mode, input logic rot,
                         input logic sr, input logic sl, input logic [7:0] d);
    bus_n.en = en; bus_n.mode = mode; bus_n.rot = rot;
    bus_n.sin_r = sr; bus_n.sin_l = sl; bus_n.d = d;
  endtask

  task automatic model_step(input logic en, input logic [1:0] mode, input logic rot,
                            input logic sr, input logic sl, input logic [7:0] d);
    logic in;
    if (!en || mode == 2'd0) begin
      m_done = 1'b0;
    end else if (mode == 2'd3) begin
      m_q = d; m_shifts = 0; m_done = 1'b0;
    end else begin
      if (mode == 2'd1) begin
        in  = rot ? m_q[0] : sr;
        m_q = (m_q >> 1) | (in ? 8'h80 : 8'h00);
      end else begin
        in  = rot ? m_q[7] : sl;
        m_q = (m_q << 1) | (in ? 8'h01 : 8'h00);
      end
      m_shifts++;
      m_done = (m_shifts % W) == 0;
    end
  endtask

  // One active (falling) edge on u_neg, checked against the model.
  task automatic do_op(input string nm, input logic en, input logic [1:0] mode,
                       input logic rot, input logic sr, input logic sl, input logic [7:0] d);
    drive_n(en, mode, rot, sr, sl, d);
    @(negedge clk); #1;
    model_step(en, mode, rot, sr, sl, d);
    chk({nm, "_q"},    32'(bus_n.q),      32'(m_q));
    chk({nm, "_cnt"},  32'(bus_n.cnt),    32'(m_shifts % W));
    chk({nm, "_done"}, 32'(bus_n.done),   32'(m_done));
    chk({nm, "_sr"},   32'(bus_n.sout_r), 32'(m_q[0]));
    chk({nm, "_sl"},   32'(bus_n.sout_l), 32'(m_q[7]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int done_edges[$];
    logic [1:0] rm;

    drive_n(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_p.en = 1'b0; bus_p.mode = 2'd0; bus_p.rot = 1'b0;
    bus_p.sin_r = 1'b0; bus_p.sin_l = 1'b0; bus_p.d = 8'h00;

    // Reset takes effect without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_q",    32'(bus_n.q),    32'h A5);
    chk("rst_async_cnt",  32'(bus_n.cnt),  32'd0);
    chk("rst_async_done", 32'(bus_n.done), 32'd0);
    chk("rst_async_pq",   32'(bus_p.q),    32'h5A);

    // Clocks with load requested under reset: nothing moves.
    drive_n(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hFF);
    bus_p.en = 1'b1; bus_p.mode = 2'd3; bus_p.d = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hold_q",  32'(bus_n.q), 32'hA5);
    chk("rst_hold_pq", 32'(bus_p.q), 32'h5A);
    bus_p.en = 1'b0;

    // Release between edges, idle in hold.
    drive_n(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_q",    32'(bus_n.q),    32'hA5);
    chk("idle_cnt",  32'(bus_n.cnt),  32'd0);
    chk("idle_done", 32'(bus_n.done), 32'd0);

    // Load is not taken on the rising edge, only on the falling edge.
    drive_n(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hFF);
    @(posedge clk); #1;
    chk("no_rise_q", 32'(bus_n.q), 32'hA5);
    @(negedge clk); #1;
    chk("fall_load_q", 32'(bus_n.q), 32'hFF);

    // Directed vector table, starting from q=FF cnt=0.
    add(1, 2'd3, 0, 0, 0, 8'h81, 8'h81, 0, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'hC0, 1, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h60, 2, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h30, 3, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h18, 4, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h0C, 5, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h06, 6, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h03, 7, 0);
    add(1, 2'd1, 1, 0, 0, 8'h00, 8'h81, 0, 1);
    add(0, 2'd1, 1, 1, 1, 8'h00, 8'h81, 0, 0);
    add(1, 2'd0, 0, 1, 1, 8'h55, 8'h81, 0, 0);
    add(1, 2'd3, 1, 1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 2'd2, 0, 0, 1, 8'h00, 8'h01, 1, 0);
    add(1, 2'd2, 0, 0, 1, 8'h00, 8'h03, 2, 0);
    add(1, 2'd2, 0, 0, 1, 8'h00, 8'h07, 3, 0);
    add(1, 2'd3, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, 2'd1, 0, 1, 0, 8'h00, 8'h80, 1, 0);
    add(1, 2'd1, 0, 1, 0, 8'h00, 8'hC0, 2, 0);
    add(1, 2'd1, 0, 1, 0, 8'h00, 8'hE0, 3, 0);
    add(1, 2'd1, 0, 0, 1, 8'h00, 8'h70, 4, 0);
    add(1, 2'd1, 0, 0, 1, 8'h00, 8'h38, 5, 0);
    add(1, 2'd3, 1, 1, 1, 8'h3C, 8'h3C, 0, 0);
    add(1, 2'd2, 0, 1, 0, 8'h00, 8'h78, 1, 0);
    add(1, 2'd1, 0, 1, 0, 8'h00, 8'hBC, 2, 0);
    add(0, 2'd1, 0, 1, 1, 8'h00, 8'hBC, 2, 0);
    add(0, 2'd1, 0, 1, 1, 8'h00, 8'hBC, 2, 0);
    add(0, 2'd1, 0, 1, 1, 8'h00, 8'hBC, 2, 0);
    add(0, 2'd1, 0, 1, 1, 8'h00, 8'hBC, 2, 0);

    foreach (tbl[i]) begin
      drive_n(tbl[i].en, tbl[i].mode, tbl[i].rot, tbl[i].sr, tbl[i].sl, tbl[i].d);
      @(negedge clk); #1;
      chk($sformatf("tbl%0d_q", i),    32'(bus_n.q),      32'(tbl[i].eq));
      chk($sformatf("tbl%0d_cnt", i),  32'(bus_n.cnt),    32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_done", i), 32'(bus_n.done),   32'(tbl[i].edone));
      chk($sformatf("tbl%0d_sr", i),   32'(bus_n.sout_r), 32'(tbl[i].eq[0]));
      chk($sformatf("tbl%0d_sl", i),   32'(bus_n.sout_l), 32'(tbl[i].eq[7]));
    end

    // Model-driven sequences from a known load.
    m_q = 8'hBC; m_shifts = 2; m_done = 1'b0;
    do_op("ld_aa", 1, 2'd3, 0, 0, 0, 8'hAA);
    for (int i = 0; i < 5; i++)
      do_op("sh5", 1, 2'd1, 0, 1'($urandom), 0, 8'h00);
    do_op("ld_3c", 1, 2'd3, 0, 0, 0, 8'h3C);
    chk("ld_3c_const_q",   32'(bus_n.q),   32'h3C);
    chk("ld_3c_const_cnt", 32'(bus_n.cnt), 32'd0);

    // Sixteen continuous shifts: done exactly on shifts 8 and 16.
    do_op("ld_00", 1, 2'd3, 0, 0, 0, 8'h00);
    done_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      do_op("cont", 1, ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2,
            1'($urandom), 1'($urandom), 1'($urandom), 8'h00);
      if (bus_n.done) begin
        done_cnt++;
        done_edges.push_back(i);
      end
    end
    chk("cont_done_count", 32'(done_cnt), 32'd2);
    if (done_edges.size() == 2) begin
      chk("cont_done_edge0", 32'(done_edges[0]), 32'd8);
      chk("cont_done_edge1", 32'(done_edges[1]), 32'd16);
    end

    // Reset asserted between edges after a partial count.
    for (int i = 0; i < 5; i++)
      do_op("pre_rst", 1, 2'd2, 0, 1, 1'($urandom), 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    32'(bus_n.q),    32'hA5);
    chk("mid_rst_cnt",  32'(bus_n.cnt),  32'd0);
    chk("mid_rst_done", 32'(bus_n.done), 32'd0);
    m_q = 8'hA5; m_shifts = 0; m_done = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      do_op("post_rst", 1, 2'd1, 0, 1'($urandom), 0, 8'h00);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      rm = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      do_op("rand", 1'($urandom_range(0, 7) != 0), rm,
            1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Rising-edge build: load then rotate-right eight times.
    drive_n(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_p.en = 1'b1; bus_p.mode = 2'd3; bus_p.rot = 1'b0; bus_p.d = 8'h81;
    @(posedge clk); #1;
    chk("pos_load_q", 32'(bus_p.q), 32'h81);
    bus_p.mode = 2'd1; bus_p.rot = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      chk($sformatf("pos_nofall%0d_q", i), 32'(bus_p.q), 32'(tbl[i-1].eq));
      @(posedge clk); #1;
      chk($sformatf("pos_rise%0d_q", i),    32'(bus_p.q),    32'(tbl[i].eq));
      chk($sformatf("pos_rise%0d_cnt", i),  32'(bus_p.cnt),  32'(tbl[i].ecnt));
      chk($sformatf("pos_rise%0d_done", i), 32'(bus_p.done), 32'(tbl[i].edone));
    end
    bus_p.en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_negedge_univ_shift_reg.md
Name: param_negedge_univ_shift_reg

Overview:
- Parametrised universal shift register: WIDTH-bit, with selectable active clock edge (falling edge by default).
- Successor to the single-bit negative-edge master-slave flip-flop. Adds:
  - asynchronous active-low reset to a programmable value;
  - hold, shift-right, shift-left and parallel-load modes, with optional rotate;
  - a shift counter that pulses `done` after every WIDTH shifts.
- Used as a serialiser/deserialiser stage in the sequential-logic library.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..32.
- NEG_EDGE, 1: 1 = state updates on the falling edge of clk; 0 = state updates on the rising edge.
- RST_VAL, 0: value of q after reset; WIDTH bits.
- CNT_W, 5: width of cnt; must satisfy 2**CNT_W > WIDTH-1.

Ports:
- clk  input  1  clock; only the edge selected by NEG_EDGE is active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  update enable; 0 holds all state.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rot  input  1  1 = rotate: the serial input is ignored and the bit shifted out is fed back in.
- sin_r  input  1  serial input entering at the MSB on a right shift.
- sin_l  input  1  serial input entering at the LSB on a left shift.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0]; combinational from q.
- sout_l  output  1  equals q[WIDTH-1]; combinational from q.
- cnt  output  CNT_W  number of shifts since the last load, reset or wrap.
- done  output  1  one-active-edge pulse after WIDTH shifts.

Behaviour:
- Reset (rst_n=0):
  - Takes effect immediately, independent of clk. q=RST_VAL, cnt=0, done=0.
  - Held for as long as rst_n=0.
  - Release is synchronous to the next active edge. The first update after release occurs on the first active edge with rst_n=1.
- All state (q, cnt, done) changes only on the active edge: negedge clk if NEG_EDGE=1, posedge clk if NEG_EDGE=0. Both edges are never used.
- Latency: q reflects the operation one active edge after sampling. Inputs are sampled at the active edge.
- en=0: q and cnt hold; done=0.
- en=1, mode=00 (hold): q holds, cnt holds, done=0.
- en=1, mode=01 (shift right):
  - q <= {in, q[WIDTH-1:1]}.
  - in = rot ? q[0] : sin_r.
- en=1, mode=10 (shift left):
  - q <= {q[WIDTH-2:0], in}.
  - in = rot ? q[WIDTH-1] : sin_l.
- en=1, mode=11 (load): q <= d, cnt <= 0, done <= 0. rot, sin_r and sin_l are ignored.
- Counter, on any shift (mode 01 or 10 with en=1):
  - If cnt == WIDTH-1: cnt <= 0 and done <= 1.
  - Otherwise: cnt <= cnt+1 and done <= 0.
  - Right and left shifts count identically. Mixing directions does not reset the count.
- done:
  - Registered. High for exactly one active-edge period after the WIDTH-th shift.
  - Cleared on the next active edge unless another wrap occurs. It cannot, for WIDTH≥2.
- Wrap-around: continuous shifting gives done every WIDTH shifts (cnt 0..WIDTH-1 repeating).
- Simultaneous reset and active edge: reset wins.
- Reset mid-shift-sequence: the partial count is discarded. Counting restarts from 0.
- sout_r and sout_l are purely combinational from q. They have no extra register.

Test Plan:
- WIDTH=8, NEG_EDGE=1, RST_VAL=8'hA5:
  - Hold rst_n=0, then release and idle with mode=00 -> q=8'hA5, cnt=0, done=0.
  - Toggle clk with rst_n=0 -> no change.
  - Verify no update occurs on the rising edge.
- Load d=8'h81 (mode=11), then 8 shift-rights with rot=1:
  - q sequence is 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81.
  - done=1 only after the 8th edge, with cnt back to 0.
- Load 8'h00, then shift-left with sin_l=1 for 3 edges -> q=8'h07, cnt=3, sout_l=0.
- Load 8'h00, then shift-right with sin_r=1 for 3 edges -> q=8'hE0, sout_r=0.
- Shift 5 times, then load 8'h3C -> cnt=0, done=0.
- Shift 5 times, then assert rst_n=0 mid-cycle (between edges) -> q=8'hA5 immediately, cnt=0.
- en=0 with mode=01 for 4 edges -> q and cnt unchanged, done=0.
- Continuous shift for 16 edges -> exactly two done pulses, each on edges 8 and 16.
- NEG_EDGE=0 build: repeat the load/shift case -> updates occur on the rising edge only.
